seven_seg_scan_ctrl: RTL

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-synchronous
// display update and optional leading-zero blanking.
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  hex,
    output logic        dp,
    output logic        enable,
    output logic [3:0]  an,
    output logic        pending
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       digit_q, digit_d;
    logic [15:0]      buf_data_q, buf_data_d;
    logic [3:0]       buf_dp_q, buf_dp_d;
    logic [15:0]      disp_data_q, disp_data_d;
    logic [3:0]       disp_dp_q, disp_dp_d;
    logic             pending_q, pending_d;

    logic tick;
    logic frame_end;

    assign tick      = (div_q == DIV_LAST);
    assign frame_end = tick && (digit_q == 2'd3);

    always_comb begin
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        digit_d     = tick ? digit_q + 2'd1 : digit_q;
        buf_data_d  = buf_data_q;
        buf_dp_d    = buf_dp_q;
        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        pending_d   = pending_q;

        // A load on the boundary cycle bypasses the buffer so it is shown at once.
        if (load && frame_end) begin
            disp_data_d = data_in;
            disp_dp_d   = dp_in;
            pending_d   = 1'b0;
        end else if (load) begin
            buf_data_d = data_in;
            buf_dp_d   = dp_in;
            pending_d  = 1'b1;
        end else if (frame_end && pending_q) begin
            disp_data_d = buf_data_q;
            disp_dp_d   = buf_dp_q;
            pending_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            digit_q     <= 2'd0;
            buf_data_q  <= 16'h0000;
            buf_dp_q    <= 4'b1111;
            disp_data_q <= 16'h0000;
            disp_dp_q   <= 4'b1111;
            pending_q   <= 1'b0;
        end else begin
            div_q       <= div_d;
            digit_q     <= digit_d;
            buf_data_q  <= buf_data_d;
            buf_dp_q    <= buf_dp_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
            pending_q   <= pending_d;
        end
    end

    always_comb begin
        an     = ~(4'b0001 << digit_q);
        hex    = disp_data_q[3:0];
        dp     = disp_dp_q[digit_q];
        enable = 1'b1;
        // Digit k is blank only when it and every more significant nibble are zero.
        case (digit_q)
            2'd0: hex = disp_data_q[3:0];
            2'd1: begin
                hex    = disp_data_q[7:4];
                enable = !(blank_lz && (disp_data_q[15:4] == 12'h000));
            end
            2'd2: begin
                hex    = disp_data_q[11:8];
                enable = !(blank_lz && (disp_data_q[15:8] == 8'h00));
            end
            default: begin
                hex    = disp_data_q[15:12];
                enable = !(blank_lz && (disp_data_q[15:12] == 4'h0));
            end
        endcase
    end

    assign pending = pending_q;

endmodule
